// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep sequencer for the DDS phase accumulator.
// Steps the tuning word from ftw_start to ftw_stop in ftw_inc increments.
// Each word is held for dwell+1 cycles. The sweep can stop on its own, on abort or on rst.
// Optional build macro DDS_SWEEP_LOOP_EN adds a 'loop' input.
// With loop set at start, the block runs a continuous triangle sweep between the two endpoints.
module dds_sweep_ctrl #(
  parameter int unsigned FTW_W   = 16,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
`ifdef DDS_SWEEP_LOOP_EN
  input  logic               loop,
`endif
  input  logic [FTW_W-1:0]   ftw_start,
  input  logic [FTW_W-1:0]   ftw_stop,
  input  logic [FTW_W-1:0]   ftw_inc,
  input  logic [DWELL_W-1:0] dwell,
  output logic [FTW_W-1:0]   ftw_out,
  output logic               dds_en,
  output logic               busy,
  output logic               done,
  output logic               dir_down
);

  localparam int unsigned EXT_W = FTW_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_lat;
  logic [FTW_W-1:0]   inc_lat;
  // Current sweep target; in loop mode it swaps with the other endpoint.
  logic [FTW_W-1:0]   stop_lat;
`ifdef DDS_SWEEP_LOOP_EN
  logic [FTW_W-1:0]   start_lat;
  logic               loop_lat;
`endif

  logic               dwell_end;
  logic               at_target;

  // Next word toward tgt: a widened add/subtract, clamped at tgt so it never wraps.
  function automatic logic [FTW_W-1:0] step_word(
    input logic [FTW_W-1:0] cur,
    input logic [FTW_W-1:0] inc,
    input logic [FTW_W-1:0] tgt,
    input logic             down
  );
    logic [EXT_W-1:0] sum;
    logic [EXT_W-1:0] diff;
    logic [FTW_W-1:0] res;
    sum  = EXT_W'(cur) + EXT_W'(inc);
    diff = EXT_W'(cur) - EXT_W'(inc);
    if (down) begin
      res = (diff[FTW_W] || (diff[FTW_W-1:0] <= tgt)) ? tgt : diff[FTW_W-1:0];
    end else begin
      res = (sum >= EXT_W'(tgt)) ? tgt : sum[FTW_W-1:0];
    end
    return res;
  endfunction

  // Dwell expiry and endpoint detection for the current word.
  always_comb begin
    dwell_end = 1'b0;
    at_target = 1'b0;
    dwell_end = (cnt == dwell_lat);
    at_target = (ftw_out == stop_lat);
  end

  // Sweep FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ftw_out   <= '0;
      dds_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dir_down  <= 1'b0;
      cnt       <= '0;
      dwell_lat <= '0;
      inc_lat   <= '0;
      stop_lat  <= '0;
`ifdef DDS_SWEEP_LOOP_EN
      start_lat <= '0;
      loop_lat  <= 1'b0;
`endif
    end else if (abort) begin
      // Abort wins everywhere: drop to IDLE, keep the current word, no done pulse.
      state  <= IDLE;
      dds_en <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dds_en <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
          if (start) begin
            stop_lat  <= ftw_stop;
            inc_lat   <= ftw_inc;
            dwell_lat <= dwell;
`ifdef DDS_SWEEP_LOOP_EN
            start_lat <= ftw_start;
            loop_lat  <= loop;
`endif
            ftw_out   <= ftw_start;
            dir_down  <= (ftw_start > ftw_stop);
            cnt       <= '0;
            dds_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end

        RUN: begin
          dds_en <= 1'b1;
          busy   <= 1'b1;
          done   <= 1'b0;
          if (!dwell_end) begin
            cnt <= cnt + DWELL_W'(1);
          end else begin
            cnt <= '0;
`ifdef DDS_SWEEP_LOOP_EN
            if (loop_lat && (inc_lat == '0)) begin
              // Zero step in loop mode: keep holding the word indefinitely.
              state <= RUN;
            end else if (loop_lat && at_target) begin
              // Endpoint reached: reverse and step straight away so endpoints are not doubled.
              stop_lat  <= start_lat;
              start_lat <= stop_lat;
              dir_down  <= ~dir_down;
              ftw_out   <= step_word(ftw_out, inc_lat, start_lat, ~dir_down);
            end else
`endif
            if (at_target || (inc_lat == '0)) begin
              state  <= DONE;
              dds_en <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              ftw_out <= step_word(ftw_out, inc_lat, stop_lat, dir_down);
            end
          end
        end

        DONE: begin
          // One-cycle done pulse; a start seen here is ignored.
          dds_en <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          dds_en <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl.
// The reference model derives the expected word sequence from the sweep rules with plain integer arithmetic.
// The loop scenario is only built when DDS_SWEEP_LOOP_EN is defined.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        loop = 1'b0;
  logic [15:0] ftw_start = '0;
  logic [15:0] ftw_stop = '0;
  logic [15:0] ftw_inc = '0;
  logic [15:0] dwell = '0;
  logic [15:0] ftw_out;
  logic        dds_en;
  logic        busy;
  logic        done;
  logic        dir_down;

  int passed = 0;
  int total  = 0;
  int exp_words[$];

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.FTW_W(16), .DWELL_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
`ifdef DDS_SWEEP_LOOP_EN
    .loop      (loop),
`endif
    .ftw_start (ftw_start),
    .ftw_stop  (ftw_stop),
    .ftw_inc   (ftw_inc),
    .dwell     (dwell),
    .ftw_out   (ftw_out),
    .dds_en    (dds_en),
    .busy      (busy),
    .done      (done),
    .dir_down  (dir_down)
  );

  // Reference model: the distinct words a single-shot sweep visits, in order.
  task automatic build_words(input int s, input int e, input int i);
    int w;
    exp_words.delete();
    w = s;
    exp_words.push_back(w);
    while (w != e && i != 0) begin
      if (s < e) begin
        w = w + i;
        if (w >= e) w = e;
      end else begin
        w = w - i;
        if (w <= e) w = e;
      end
      exp_words.push_back(w);
    end
  endtask

  // One full sweep: each held cycle, the done cycle, and the idle cycle after it.
  // Optional jitter changes config inputs and pulses start while the block is busy.
  task automatic run_sweep(input string name, input int s, input int e,
                           input int i, input int d, input bit jitter);
    logic [19:0] obs, exp;
    logic        exp_dir;
    int          cyc;
    int          last;
    build_words(s, e, i);
    exp_dir = (s > e);
    last = exp_words[exp_words.size()-1];
    @(negedge clk);
    ftw_start = 16'(s); ftw_stop = 16'(e); ftw_inc = 16'(i); dwell = 16'(d);
    start = 1'b1;
    cyc = 0;
    foreach (exp_words[k]) begin
      for (int h = 0; h <= d; h++) begin
        @(negedge clk);
        cyc++;
        start = jitter ? 1'($urandom_range(0, 1)) : 1'b0;
        if (jitter) begin
          ftw_start = 16'($urandom); ftw_stop = 16'($urandom);
          ftw_inc = 16'($urandom); dwell = 16'($urandom);
        end
        obs = {ftw_out, dds_en, busy, done, dir_down};
        exp = {16'(exp_words[k]), 1'b1, 1'b1, 1'b0, exp_dir};
        total++;
        if (obs !== exp)
          $display("FAIL %s cyc%0d: got ftw=%h en=%b busy=%b done=%b dir=%b, expected ftw=%h en=%b busy=%b done=%b dir=%b",
                   name, cyc, obs[19:4], obs[3], obs[2], obs[1], obs[0], exp[19:4], exp[3], exp[2], exp[1], exp[0]);
        else passed++;
      end
    end
    @(negedge clk);
    cyc++;
    start = jitter ? 1'($urandom_range(0, 1)) : 1'b0;
    obs = {ftw_out, dds_en, busy, done, dir_down};
    exp = {16'(last), 1'b0, 1'b0, 1'b1, exp_dir};
    total++;
    if (obs !== exp)
      $display("FAIL %s done_cycle: got %h expected %h", name, obs, exp);
    else passed++;
    @(negedge clk);
    start = 1'b0;
    obs = {ftw_out, dds_en, busy, done, dir_down};
    exp = {16'(last), 1'b0, 1'b0, 1'b0, exp_dir};
    total++;
    if (obs !== exp)
      $display("FAIL %s idle_after: got %h expected %h", name, obs, exp);
    else passed++;
  endtask

  task automatic test_reset();
    logic [19:0] obs;
    rst = 1'b1;
    #12;
    obs = {ftw_out, dds_en, busy, done, dir_down};
    total++;
    if (obs !== 20'h0) $display("FAIL reset_values: got %h expected %h", obs, 20'h0);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_up_sweep();
    run_sweep("up_sweep", 100, 130, 10, 3, 1'b0);
  endtask

  task automatic test_saturation();
    run_sweep("saturation", 100, 125, 10, 0, 1'b0);
  endtask

  task automatic test_down_edge();
    run_sweep("down_edge", 16'hFFF0, 16'h0005, 16'h8000, 1, 1'b0);
  endtask

  task automatic test_degenerate();
    run_sweep("inc_zero", 50, 90, 0, 2, 1'b0);
    run_sweep("start_eq_stop", 7, 7, 3, 1, 1'b0);
  endtask

  task automatic test_random();
    int s, e, span, i, d;
    for (int n = 0; n < 25; n++) begin
      s = int'($urandom_range(0, 65535));
      e = (n % 8 == 3) ? s : int'($urandom_range(0, 65535));
      span = (s > e) ? s - e : e - s;
      i = (n % 8 == 5) ? 0 : int'($urandom_range(span / 20 + 1, 65535));
      d = int'($urandom_range(0, 3));
      run_sweep("random", s, e, i, d, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    run_sweep("b2b_first", 200, 170, 10, 0, 1'b0);
    run_sweep("b2b_second", 170, 200, 15, 1, 1'b1);
  endtask

  task automatic test_abort();
    logic [19:0] obs, exp;
    @(negedge clk);
    ftw_start = 16'd0; ftw_stop = 16'd90; ftw_inc = 16'd10; dwell = 16'd2;
    start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      start = (c == 7);
      obs = {ftw_out, dds_en, busy, done, dir_down};
      exp = {16'(((c - 1) / 3) * 10), 1'b1, 1'b1, 1'b0, 1'b0};
      total++;
      if (obs !== exp) $display("FAIL abort_run cyc%0d: got %h expected %h", c, obs, exp);
      else passed++;
      if (c == 13) abort = 1'b1;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      abort = 1'b0;
      obs = {ftw_out, dds_en, busy, done, dir_down};
      exp = {16'd40, 1'b0, 1'b0, 1'b0, 1'b0};
      total++;
      if (obs !== exp) $display("FAIL abort_hold %0d: got %h expected %h", c, obs, exp);
      else passed++;
    end
    // start together with abort in IDLE must not launch a sweep
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    obs = {ftw_out, dds_en, busy, done, dir_down};
    exp = {16'd40, 1'b0, 1'b0, 1'b0, 1'b0};
    total++;
    if (obs !== exp) $display("FAIL abort_with_start: got %h expected %h", obs, exp);
    else passed++;
  endtask

  task automatic test_rst_mid();
    logic [19:0] obs;
    @(negedge clk);
    ftw_start = 16'd2000; ftw_stop = 16'd1000; ftw_inc = 16'd100; dwell = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (!(busy === 1'b1 && dir_down === 1'b1))
      $display("FAIL rst_pre: got busy=%b dir=%b expected busy=1 dir=1", busy, dir_down);
    else passed++;
    #2 rst = 1'b1;
    #1;
    obs = {ftw_out, dds_en, busy, done, dir_down};
    total++;
    if (obs !== 20'h0) $display("FAIL rst_immediate: got %h expected %h", obs, 20'h0);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    obs = {ftw_out, dds_en, busy, done, dir_down};
    total++;
    if (obs !== 20'h0) $display("FAIL rst_after: got %h expected %h", obs, 20'h0);
    else passed++;
  endtask

`ifdef DDS_SWEEP_LOOP_EN
  task automatic test_loop();
    logic [19:0] obs, exp;
    int w, lo, hi;
    bit up;
    lo = 10; hi = 30; w = 10; up = 1'b1;
    @(negedge clk);
    ftw_start = 16'd10; ftw_stop = 16'd30; ftw_inc = 16'd10; dwell = 16'd0;
    loop = 1'b1; start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0; loop = 1'b0;
      obs = {ftw_out, dds_en, busy, done, dir_down};
      exp = {16'(w), 1'b1, 1'b1, 1'b0, ~up};
      total++;
      if (obs !== exp) $display("FAIL loop cyc%0d: got %h expected %h", c, obs, exp);
      else passed++;
      if (w == (up ? hi : lo)) up = ~up;
      w = up ? ((w + 10 >= hi) ? hi : w + 10) : ((w - 10 <= lo) ? lo : w - 10);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (!(busy === 1'b0 && dds_en === 1'b0 && done === 1'b0))
      $display("FAIL loop_abort: got busy=%b en=%b done=%b expected 0 0 0", busy, dds_en, done);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_up_sweep();
    test_saturation();
    test_down_edge();
    test_degenerate();
    test_back_to_back();
    test_abort();
    test_random();
    test_rst_mid();
`ifdef DDS_SWEEP_LOOP_EN
    test_loop();
    run_sweep("loop_off", 10, 30, 10, 0, 1'b0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Frequency-sweep sequencer for the DDS phase-accumulator generators.
- Drives the tuning word (phase step) and the accumulator enable.
- Steps the tuning word from a start value to a stop value in fixed increments, holding each value for a programmable dwell.
- Sits between the control/config logic (start/abort, sweep registers) and the DDS core's phase-step input.

Parameters:
FTW_W, 16, tuning-word width (matches DDS phase-step input width)
DWELL_W, 16, dwell counter width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  begin sweep; sampled only in IDLE
abort  input  1  terminate sweep immediately; priority over start
ftw_start  input  FTW_W  first tuning word
ftw_stop  input  FTW_W  final tuning word
ftw_inc  input  FTW_W  step magnitude (unsigned)
dwell  input  DWELL_W  hold each tuning word for dwell+1 cycles
ftw_out  output  FTW_W  tuning word to DDS phase-step input
dds_en  output  1  DDS accumulator enable
busy  output  1  sweep in progress
done  output  1  single-cycle pulse on normal completion
dir_down  output  1  1 = current sweep direction is descending

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. All state is reset by rst.
- Reset values: state=IDLE, ftw_out=0, dds_en=0, busy=0, done=0, dir_down=0, dwell counter=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - dds_en=0; busy=0; ftw_out holds its last value.
  - start=1 and abort=0 latches ftw_stop, ftw_inc and dwell into shadow registers.
  - On that same edge: ftw_out<=ftw_start, dir_down<=(ftw_start>ftw_stop), cnt<=0, next state RUN.
- Latency: start sampled at edge N gives busy=1, dds_en=1, ftw_out=ftw_start valid after edge N+1.
- RUN:
  - dds_en=1; busy=1; cnt increments every cycle.
  - Dwell end is cnt==dwell_lat.
  - At dwell end with ftw_out==stop_lat or inc_lat==0: next state DONE.
  - Otherwise, ascending: ftw_out<=min(ftw_out+inc_lat, stop_lat), computed at FTW_W+1 bits so there is no wrap-around.
  - Otherwise, descending: ftw_out<=max(ftw_out-inc_lat, stop_lat), computed at FTW_W+1 bits so there is no underflow wrap.
  - cnt<=0 on every step.
  - Every tuning word, including the last saturated one, is held exactly dwell+1 cycles.
- DONE:
  - done=1 for exactly one cycle; busy=0; dds_en=0; ftw_out holds stop_lat; next state IDLE.
  - A start in DONE is ignored.
- Total run length = (number of distinct words) × (dwell+1) cycles.
- start while busy: ignored.
- Input config changes during RUN: ignored (shadow registers are used).
- abort=1 in any state: next state IDLE, dds_en=0, busy=0, no done pulse, ftw_out holds its current value. abort and start together in IDLE: stay IDLE.
- ftw_start==ftw_stop: a single word is held dwell+1 cycles, then done.
- dwell=0: one cycle per word.
- rst mid-sweep: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: DDS_SWEEP_LOOP_EN.
- When defined:
  - Adds input port loop (1 bit), latched at start.
  - If loop_lat=1, completion at a sweep endpoint does not enter DONE. Instead the sweep reverses:
    - dir_down toggles;
    - target swaps between ftw_stop and ftw_start (both latched);
    - stepping continues after the endpoint's dwell.
  - The result is a continuous triangle sweep that ends only on abort or rst. done is never asserted in loop mode. Endpoint words are held one dwell only; they are not doubled.
  - If loop_lat=0, behaviour is identical to the base block.
- When undefined: no loop port; single-shot sweep only.

Test Plan:
- Up sweep: ftw_start=100, stop=130, inc=10, dwell=3, start at cycle 0 -> ftw_out=100,110,120,130, each for 4 cycles (cycles 1-16); done=1 at cycle 17; busy falls at cycle 17.
- Saturation: start=100, stop=125, inc=10, dwell=0 -> 100,110,120,125, one cycle each, then done; a value of 130 never appears.
- Down sweep plus edge: start=0xFFF0, stop=0x0005, inc=0x8000, dwell=1 -> dir_down=1; words 0xFFF0, 0x7FF0, 0x0005, each 2 cycles; no wrap.
- Degenerate cases: inc=0, start=50, stop=90 -> 50 held dwell+1 cycles, then done. Separately, start==stop=7 -> 7 held, then done.
- Abort/ignore: start a 10-step sweep, pulse start again at step 2 (ignored), then abort at step 4 -> next cycle busy=0, dds_en=0, ftw_out holds the step-4 word, no done. Separately, assert rst mid-sweep -> all outputs take reset values immediately.
- DDS_SWEEP_LOOP_EN: loop=1, start=10, stop=30, inc=10, dwell=0 -> 10,20,30,20,10,20,... with no done; abort ends it.
